riscv_inst_unpack_queue: RTL and testbench

- Decode-side counterpart to the instruction message packer: accepts raw 32-bit RISC-V instruction words on a val/rdy interface and splits each into its fields.
- Classifies each word as R/I/S/SB/U/UJ format and reassembles the 32-bit sign-extended immediate.
- Buffers decoded results in a small FIFO and presents them on a val/rdy output.
- Sits between instruction fetch and the issue/decode logic of the IO2I pipeline.

---
 rtl/riscv_inst_unpack_queue_if.sv | 31 +++
 rtl/riscv_inst_unpack_queue.sv | 131 +++++++++++++
 tb/tb_riscv_inst_unpack_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_inst_unpack_queue_if.sv
// Handshake bundle for the instruction unpack queue: raw word in, decoded head entry out.
// The slave modport is the queue; the master modport is fetch plus the issue consumer.
interface riscv_inst_unpack_queue_if;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_inst;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;

    modport slave (
        input  in_val, in_inst, out_rdy,
        output in_rdy, out_val, out_inst, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal
    );

    modport master (
        output in_val, in_inst, out_rdy,
        input  in_rdy, out_val, out_inst, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_fmt, out_imm, out_illegal
    );
endinterface

// File: rtl/riscv_inst_unpack_queue.sv
// Decodes raw RISC-V instruction words into fields, format and immediate, and buffers
// the decoded entries in a small FIFO with val/rdy on both sides.
module riscv_inst_unpack_queue #(
    parameter int unsigned p_num_entries = 2,
    parameter int unsigned p_cnt_sz      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    riscv_inst_unpack_queue_if.slave q,
    output logic [p_cnt_sz-1:0]      illegal_cnt
);
    localparam int unsigned ptr_w = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int unsigned cnt_w = ptr_w + 1;

    localparam logic [2:0] fmt_r   = 3'd0;
    localparam logic [2:0] fmt_i   = 3'd1;
    localparam logic [2:0] fmt_s   = 3'd2;
    localparam logic [2:0] fmt_sb  = 3'd3;
    localparam logic [2:0] fmt_u   = 3'd4;
    localparam logic [2:0] fmt_uj  = 3'd5;
    localparam logic [2:0] fmt_ill = 3'd7;

    typedef struct packed {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        illegal;
    } entry_t;

    entry_t             mem [p_num_entries];
    entry_t             dec;
    entry_t             head;
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               live;
    logic               full;
    logic               empty;
    logic               enq;
    logic               deq;

    // Format classification and immediate reassembly of the incoming word
    always_comb begin
        dec         = '0;
        dec.inst    = q.in_inst;
        dec.fmt     = fmt_ill;
        dec.illegal = 1'b1;
        case (q.in_inst[6:0])
            7'b0110011: begin
                dec.fmt     = fmt_r;
                dec.illegal = 1'b0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec.fmt     = fmt_i;
                dec.illegal = 1'b0;
                dec.imm     = {{20{q.in_inst[31]}}, q.in_inst[31:20]};
            end
            7'b0100011: begin
                dec.fmt     = fmt_s;
                dec.illegal = 1'b0;
                dec.imm     = {{20{q.in_inst[31]}}, q.in_inst[31:25], q.in_inst[11:7]};
            end
            7'b1100011: begin
                dec.fmt     = fmt_sb;
                dec.illegal = 1'b0;
                dec.imm     = {{19{q.in_inst[31]}}, q.in_inst[31], q.in_inst[7],
                               q.in_inst[30:25], q.in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt     = fmt_u;
                dec.illegal = 1'b0;
                dec.imm     = {q.in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec.fmt     = fmt_uj;
                dec.illegal = 1'b0;
                dec.imm     = {{11{q.in_inst[31]}}, q.in_inst[31], q.in_inst[19:12],
                               q.in_inst[20], q.in_inst[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    assign full  = (count == cnt_w'(p_num_entries));
    assign empty = (count == '0);
    assign enq   = q.in_val && q.in_rdy;
    assign deq   = q.out_val && q.out_rdy;
    assign head  = mem[rd_ptr];

    // live keeps in_rdy low until the first edge after reset releases
    assign q.in_rdy      = live && !full;
    assign q.out_val     = !empty;
    assign q.out_inst    = head.inst;
    assign q.out_opcode  = head.inst[6:0];
    assign q.out_rd      = head.inst[11:7];
    assign q.out_funct3  = head.inst[14:12];
    assign q.out_rs1     = head.inst[19:15];
    assign q.out_rs2     = head.inst[24:20];
    assign q.out_funct7  = head.inst[31:25];
    assign q.out_fmt     = head.fmt;
    assign q.out_imm     = head.imm;
    assign q.out_illegal = head.illegal;

    // Queue storage, pointers, occupancy and the saturating illegal counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(p_num_entries); i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            live        <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (enq) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + ptr_w'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
                if (head.illegal && (illegal_cnt != '1))
                    illegal_cnt <= illegal_cnt + p_cnt_sz'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_inst_unpack_queue.sv
// Self-checking bench for riscv_inst_unpack_queue: directed test-plan steps followed by
// random traffic, all checked against a queue-based reference model.
module tb_riscv_inst_unpack_queue;
    localparam int unsigned N    = 2;
    localparam int unsigned CW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] illegal_cnt;

    riscv_inst_unpack_queue_if bus ();

    riscv_inst_unpack_queue #(.p_num_entries(N), .p_cnt_sz(CW)) dut (
        .clk(clk), .reset(reset), .q(bus), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mq[$];
    int          mcnt = 0;
    bit          mready = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode: immediates built by placing bits at the top and arithmetic-shifting down
    function automatic logic [99:0] expect_head(input logic [31:0] i);
        logic signed [31:0] t;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
        fmt = 3'd7; imm = 32'd0; ill = 1'b1;
        if (i[6:0] == 7'h33) begin fmt = 3'd0; ill = 1'b0; end
        else if (i[6:0] == 7'h13 || i[6:0] == 7'h03 || i[6:0] == 7'h67) begin
            fmt = 3'd1; ill = 1'b0; t = i; imm = 32'(t >>> 20);
        end else if (i[6:0] == 7'h23) begin
            fmt = 3'd2; ill = 1'b0; t = {i[31:25], i[11:7], 20'b0}; imm = 32'(t >>> 20);
        end else if (i[6:0] == 7'h63) begin
            fmt = 3'd3; ill = 1'b0;
            t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}; imm = 32'(t >>> 19);
        end else if (i[6:0] == 7'h37 || i[6:0] == 7'h17) begin
            fmt = 3'd4; ill = 1'b0; imm = i & 32'hFFFF_F000;
        end else if (i[6:0] == 7'h6F) begin
            fmt = 3'd5; ill = 1'b0;
            t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}; imm = 32'(t >>> 11);
        end
        return {i, i[6:0], i[11:7], i[14:12], i[19:15], i[24:20], i[31:25], fmt, imm, ill};
    endfunction

    function automatic logic [99:0] head_obs();
        return {bus.out_inst, bus.out_opcode, bus.out_rd, bus.out_funct3, bus.out_rs1,
                bus.out_rs2, bus.out_funct7, bus.out_fmt, bus.out_imm, bus.out_illegal};
    endfunction

    // Check outputs against the model, then advance one clock and update the model
    task automatic tick();
        bit enq, deq;
        logic [99:0] h;
        chk("in_rdy", 128'(bus.in_rdy), 128'(mready && (mq.size() < N)));
        chk("out_val", 128'(bus.out_val), 128'(mq.size() != 0));
        if (mq.size() != 0) chk("head", 128'(head_obs()), 128'(expect_head(mq[0])));
        chk("illegal_cnt", 128'(illegal_cnt), 128'(mcnt));
        enq = bus.in_val && mready && (mq.size() < N);
        deq = (mq.size() != 0) && bus.out_rdy;
        @(posedge clk);
        if (reset) begin
            mq.delete(); mcnt = 0; mready = 0;
        end else begin
            if (deq) begin
                h = expect_head(mq[0]);
                if (h[0] && mcnt < CMAX) mcnt++;
                void'(mq.pop_front());
            end
            if (enq) mq.push_back(bus.in_inst);
            mready = 1;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input bit rdy);
        bus.in_val = v; bus.in_inst = inst; bus.out_rdy = rdy;
    endtask

    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] r;
        drive(0, 32'd0, 0);
        #1;
        chk("reset_out_val", 128'(bus.out_val), 128'(0));
        chk("reset_in_rdy", 128'(bus.in_rdy), 128'(0));
        chk("reset_head", 128'(head_obs()), 128'(0));
        tick(); tick();
        #2 reset = 1'b0;
        tick();

        // 1: ADD through an empty queue
        drive(1, 32'h0030_0233, 1); tick();
        drive(0, 32'd0, 1);
        chk("add_val", 128'(bus.out_val), 128'(1));
        chk("add_fmt_rd_rs", 128'({bus.out_fmt, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_funct7}),
            128'({3'd0, 5'd4, 5'd0, 5'd3, 7'd0}));
        chk("add_imm", 128'(bus.out_imm), 128'(0));
        tick();
        chk("add_gone", 128'(bus.out_val), 128'(0));

        // 2: ADDI, SW, LUI back to back
        drive(1, 32'h8AD9_8793, 1); tick();
        drive(1, 32'hFE06_2FA3, 1);
        chk("addi", 128'({bus.out_fmt, bus.out_rd, bus.out_rs1, bus.out_imm}),
            128'({3'd1, 5'd15, 5'd19, 32'hFFFF_F8AD}));
        tick();
        drive(1, 32'hDEAD_B8B7, 1);
        chk("sw", 128'({bus.out_fmt, bus.out_rs1, bus.out_rs2, bus.out_funct3, bus.out_imm}),
            128'({3'd2, 5'd12, 5'd0, 3'd2, 32'hFFFF_FFFF}));
        tick();
        drive(0, 32'd0, 1);
        chk("lui", 128'({bus.out_fmt, bus.out_rd, bus.out_imm}), 128'({3'd4, 5'd17, 32'hDEAD_B000}));
        tick();

        // 3: BEQ and JAL
        drive(1, 32'hFE00_0EE3, 1); tick();
        drive(1, 32'hFF9F_F0EF, 1);
        chk("beq", 128'({bus.out_fmt, bus.out_imm}), 128'({3'd3, 32'hFFFF_FFFC}));
        tick();
        drive(0, 32'd0, 1);
        chk("jal", 128'({bus.out_fmt, bus.out_rd, bus.out_imm}), 128'({3'd5, 5'd1, 32'hFFFF_FFF8}));
        tick();

        // 4: fill with the consumer stalled, then drain
        drive(1, 32'h0020_8133, 0); tick();
        drive(1, 32'h0051_0193, 0); tick();
        drive(1, 32'h0000_0037, 0); tick(); tick();
        chk("full_in_rdy", 128'(bus.in_rdy), 128'(0));
        chk("full_head", 128'(bus.out_inst), 128'(32'h0020_8133));
        drive(0, 32'd0, 1); tick();
        chk("drain_in_rdy", 128'(bus.in_rdy), 128'(1));
        chk("drain_order", 128'(bus.out_inst), 128'(32'h0051_0193));
        tick();
        chk("drain_empty", 128'(bus.out_val), 128'(0));

        // 5: illegal counting and saturation
        for (int k = 0; k < 3; k++) begin drive(1, 32'h0000_007F, 1); tick(); end
        drive(0, 32'd0, 1);
        chk("illegal_head", 128'({bus.out_illegal, bus.out_fmt, bus.out_imm}), 128'({1'b1, 3'd7, 32'd0}));
        tick();
        chk("illegal_cnt3", 128'(illegal_cnt), 128'(3));
        drive(1, 32'h0000_007F, 1); tick();
        drive(0, 32'd0, 1); tick();
        chk("illegal_sat", 128'(illegal_cnt), 128'(3));

        // 6: asynchronous reset with two entries buffered
        drive(1, 32'h0000_007F, 0); tick();
        drive(1, 32'h0010_0093, 0); tick();
        drive(0, 32'd0, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_out_val", 128'(bus.out_val), 128'(0));
        chk("async_cnt", 128'(illegal_cnt), 128'(0));
        chk("async_head", 128'(head_obs()), 128'(0));
        mq.delete(); mcnt = 0; mready = 0;
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        drive(1, 32'h0040_0213, 1); tick();
        drive(0, 32'd0, 1);
        chk("post_reset_head", 128'(bus.out_inst), 128'(32'h0040_0213));
        tick();
        chk("post_reset_alone", 128'(bus.out_val), 128'(0));

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            r = $urandom();
            if ($urandom_range(3) != 0) r[6:0] = ops[$urandom_range(8)];
            drive(bit'($urandom_range(1)), r, bit'($urandom_range(3) != 0));
            tick();
        end
        drive(0, 32'd0, 1);
        for (int c = 0; c < 4; c++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
